fwd_hazard_unit: RTL

- Parametrised successor to the two-stage forwarding unit. Resolves RAW hazards for the EX stage across NSTAGES later pipeline stages.
- Detects load-use hazards for the ID stage.
- Tracks one in-flight multi-cycle op (multiplier) with a countdown scoreboard and stalls dependent or structurally conflicting instructions.
- Sits beside the hazard/flush logic between ID/EX and the pipeline registers.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/fwd_hazard_unit_fwd_select.sv | 29 ++
 rtl/fwd_hazard_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: register index type, multiplier FSM states, forward-select constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

    // Default architectural register index width.
    localparam int REGW_DEF = 5;

    typedef logic [REGW_DEF-1:0] regbits_t;

    // Multiplier tracking FSM states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

    // Forward select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

endpackage : cpu_types_pkg

// File: rtl/fwd_hazard_unit_fwd_select.sv
// Priority matcher: compares one EX source against every post-EX stage destination.
// Latency: combinational.
// Backpressure: none; the youngest matching writer (lowest stage index) wins, x0 never matches.
module fwd_select
    import cpu_types_pkg::*;
#(
    parameter int NSTAGES = 2,
    parameter int REGW    = 5,
    parameter int SELW    = $clog2(NSTAGES + 1)
) (
    input  logic [REGW-1:0]         rs_i,
    input  logic [NSTAGES*REGW-1:0] rd_stage_i,
    input  logic [NSTAGES-1:0]      wen_stage_i,
    output logic [SELW-1:0]         sel_o
);

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        sel_o = SELW'(FWD_RF);
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (wen_stage_i[k] &&
                (rd_stage_i[k*REGW +: REGW] != '0) &&
                (rd_stage_i[k*REGW +: REGW] == rs_i)) begin
                sel_o = SELW'(k + 1);
            end
        end
    end

endmodule : fwd_select

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding, ID load-use detection and single-op multiplier scoreboard.
// Latency: forward selects and stall are combinational; multiplier tracking is a registered FSM.
// Backpressure: stall_id holds PC/IF/ID and bubbles EX; a stalled or flushed multiply does not issue.
// Optional statistics counters are enabled with the FWD_HAZARD_STATS_EN macro.
module fwd_hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int NSTAGES = 2,
    parameter int REGW    = 5,
    parameter int MUL_LAT = 3,
    parameter int SELW    = $clog2(NSTAGES + 1)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [REGW-1:0]         rs1_ex,
    input  logic [REGW-1:0]         rs2_ex,
    input  logic [NSTAGES*REGW-1:0] rd_stage,
    input  logic [NSTAGES-1:0]      wen_stage,
    input  logic [REGW-1:0]         rs1_id,
    input  logic [REGW-1:0]         rs2_id,
    input  logic                    id_is_mul,
    input  logic [REGW-1:0]         rd_ex,
    input  logic                    wen_ex,
    input  logic                    ex_is_load,
    input  logic                    ex_is_mul,
    input  logic                    flush,
    output logic [SELW-1:0]         fwd_a,
    output logic [SELW-1:0]         fwd_b,
    output logic                    stall_id,
    output logic                    mul_busy
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]             fwd_count,
    output logic [31:0]             lu_stall_count,
    output logic [31:0]             sb_stall_count
`endif
);

    localparam int CNTW = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;

    mul_state_t      state_q;
    logic [CNTW-1:0] cnt_q;
    logic [REGW-1:0] pend_rd_q;

    logic lu;
    logic sb;
    logic mul_issue;

    // Source 1 forwarding select.
    fwd_select #(
        .NSTAGES (NSTAGES),
        .REGW    (REGW),
        .SELW    (SELW)
    ) u_fwd_a (
        .rs_i        (rs1_ex),
        .rd_stage_i  (rd_stage),
        .wen_stage_i (wen_stage),
        .sel_o       (fwd_a)
    );

    // Source 2 forwarding select.
    fwd_select #(
        .NSTAGES (NSTAGES),
        .REGW    (REGW),
        .SELW    (SELW)
    ) u_fwd_b (
        .rs_i        (rs2_ex),
        .rd_stage_i  (rd_stage),
        .wen_stage_i (wen_stage),
        .sel_o       (fwd_b)
    );

    // Hazard detection: load-use against the EX load, scoreboard against the in-flight multiply.
    always_comb begin
        lu = wen_ex && ex_is_load && !flush && (rd_ex != '0) &&
             ((rd_ex == rs1_id) || (rd_ex == rs2_id));
        sb = mul_busy &&
             (((pend_rd_q != '0) && ((pend_rd_q == rs1_id) || (pend_rd_q == rs2_id))) ||
              id_is_mul);
        stall_id  = lu || sb;
        mul_issue = ex_is_mul && !flush && !stall_id;
    end

    assign mul_busy = (state_q == BUSY);

    // Multiplier countdown FSM; a flush never cancels an op already in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_rd_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_issue) begin
                        state_q   <= BUSY;
                        cnt_q     <= CNTW'(MUL_LAT);
                        pend_rd_q <= wen_ex ? rd_ex : '0;
                    end
                end
                BUSY: begin
                    if (cnt_q == CNTW'(1)) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        pend_rd_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    pend_rd_q <= '0;
                end
            endcase
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] fwd_cnt_q;
    logic [31:0] lu_cnt_q;
    logic [31:0] sb_cnt_q;

    // Saturating event counters, one increment per qualifying cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fwd_cnt_q <= '0;
            lu_cnt_q  <= '0;
            sb_cnt_q  <= '0;
        end else begin
            if (((fwd_a != SELW'(FWD_RF)) || (fwd_b != SELW'(FWD_RF))) && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
            if (lu && (lu_cnt_q != '1)) begin
                lu_cnt_q <= lu_cnt_q + 32'd1;
            end
            if (sb && !lu && (sb_cnt_q != '1)) begin
                sb_cnt_q <= sb_cnt_q + 32'd1;
            end
        end
    end

    assign fwd_count      = fwd_cnt_q;
    assign lu_stall_count = lu_cnt_q;
    assign sb_stall_count = sb_cnt_q;
`endif

endmodule : fwd_hazard_unit
